// File: rtl/imem_fetch_ctrl_pkg.sv
// Shared types and constants for the instruction-fetch controller.
// The fetch FSM has two states; widths here are fixed by the memory and consumer bus.
package imem_fetch_ctrl_pkg;

    localparam int PC_W_DEF = 8;
    localparam int INST_W   = 32;
    localparam int IADDR_W  = 6;
    localparam int FCNT_W   = 16;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } fetch_state_t;

    function automatic logic [FCNT_W-1:0] sat_inc(input logic [FCNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/imem_fetch_ctrl_if.sv
// Control, memory and consumer signals of the fetch controller.
// The slave modport is the controller's view; master is the driver/consumer side.
interface imem_fetch_ctrl_if #(
    parameter int PC_W = imem_fetch_ctrl_pkg::PC_W_DEF
);
    import imem_fetch_ctrl_pkg::*;

    logic                start;
    logic [PC_W-1:0]     start_pc;
    logic                halt;
    logic                redirect;
    logic [PC_W-1:0]     redirect_pc;
    logic [IADDR_W-1:0]  imem_addr;
    logic [INST_W-1:0]   imem_data;
    logic                inst_valid;
    logic                inst_ready;
    logic [INST_W-1:0]   inst_data;
    logic [PC_W-1:0]     inst_pc;
    logic                busy;
    logic [FCNT_W-1:0]   fetch_count;

    modport slave (
        input  start, start_pc, halt, redirect, redirect_pc, imem_data, inst_ready,
        output imem_addr, inst_valid, inst_data, inst_pc, busy, fetch_count
    );

    modport master (
        output start, start_pc, halt, redirect, redirect_pc, imem_data, inst_ready,
        input  imem_addr, inst_valid, inst_data, inst_pc, busy, fetch_count
    );

endinterface

// File: rtl/imem_fetch_ctrl_fifo.sv
// Small fetch queue holding {pc, instruction} pairs; flush beats push and pop.
// Head outputs read as zero while the queue is empty.
module fetch_fifo #(
    parameter int DEPTH  = 2,
    parameter int PC_W   = 8,
    parameter int DATA_W = 32,
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_push,
    input  logic              i_pop,
    input  logic              i_flush,
    input  logic [PC_W-1:0]   i_pc,
    input  logic [DATA_W-1:0] i_data,
    output logic [CNT_W-1:0]  o_count,
    output logic              o_full,
    output logic [PC_W-1:0]   o_head_pc,
    output logic [DATA_W-1:0] o_head_data
);

    logic [PC_W-1:0]   r_pc_mem   [DEPTH];
    logic [DATA_W-1:0] r_data_mem [DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]  r_count;
    logic              w_empty;
    logic              w_do_pop;
    logic              w_do_push;

    assign w_empty   = (r_count == '0);
    assign o_full    = (r_count == CNT_W'(DEPTH));
    assign w_do_pop  = i_pop && !w_empty && !i_flush;
    // A pop in the same cycle frees the slot, so a full queue can still accept.
    assign w_do_push = i_push && !i_flush && (!o_full || w_do_pop);

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            r_count <= r_count + CNT_W'(w_do_push) - CNT_W'(w_do_pop);
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_do_push) begin
            r_pc_mem[r_wr_ptr]   <= i_pc;
            r_data_mem[r_wr_ptr] <= i_data;
        end
    end

    assign o_count     = r_count;
    assign o_head_pc   = w_empty ? '0 : r_pc_mem[r_rd_ptr];
    assign o_head_data = w_empty ? '0 : r_data_mem[r_rd_ptr];

endmodule

// File: rtl/imem_fetch_ctrl.sv
// Instruction-fetch controller: IDLE/RUN FSM, program counter, fetch counter,
// and a fetch queue feeding the consumer with one-cycle fetch latency.
module imem_fetch_ctrl
    import imem_fetch_ctrl_pkg::*;
#(
    parameter int PC_W  = PC_W_DEF,
    parameter int DEPTH = 2
) (
    input  logic             i_clk,
    input  logic             i_reset,
    imem_fetch_ctrl_if.slave bus
);

    localparam int CNT_W = $clog2(DEPTH) + 1;

    fetch_state_t      r_state;
    fetch_state_t      w_state_nxt;
    logic [PC_W-1:0]   r_pc;
    logic [PC_W-1:0]   w_pc_nxt;
    logic [FCNT_W-1:0] r_fetch_cnt;
    logic              w_push;
    logic              w_flush;
    logic              w_pop;
    logic              w_full;
    logic [CNT_W-1:0]  w_count;
    logic [PC_W-1:0]   w_head_pc;
    logic [INST_W-1:0] w_head_data;

    assign w_pop = bus.inst_valid && bus.inst_ready;

    // Priority: halt > redirect > start; start only matters in IDLE.
    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_push      = 1'b0;
        w_flush     = 1'b0;
        if (bus.halt) begin
            w_state_nxt = ST_IDLE;
            w_flush     = 1'b1;
        end else if (bus.redirect) begin
            w_flush  = 1'b1;
            w_pc_nxt = {bus.redirect_pc[PC_W-1:2], 2'b00};
        end else if (r_state == ST_IDLE) begin
            if (bus.start) begin
                w_state_nxt = ST_RUN;
                w_pc_nxt    = {bus.start_pc[PC_W-1:2], 2'b00};
            end
        end else if (!w_full || w_pop) begin
            w_push   = 1'b1;
            w_pc_nxt = r_pc + PC_W'(4);
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state     <= ST_IDLE;
            r_pc        <= '0;
            r_fetch_cnt <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
            if (w_push) r_fetch_cnt <= sat_inc(r_fetch_cnt);
        end
    end

    fetch_fifo #(
        .DEPTH  (DEPTH),
        .PC_W   (PC_W),
        .DATA_W (INST_W)
    ) u_fifo (
        .i_clk       (i_clk),
        .i_reset     (i_reset),
        .i_push      (w_push),
        .i_pop       (w_pop),
        .i_flush     (w_flush),
        .i_pc        (r_pc),
        .i_data      (bus.imem_data),
        .o_count     (w_count),
        .o_full      (w_full),
        .o_head_pc   (w_head_pc),
        .o_head_data (w_head_data)
    );

    // Word address is pc[7:2]; narrower pcs are zero-extended.
    if (PC_W >= 8) begin : g_addr_wide
        assign bus.imem_addr = r_pc[7:2];
    end else begin : g_addr_narrow
        assign bus.imem_addr = IADDR_W'(r_pc[PC_W-1:2]);
    end

    assign bus.inst_valid  = (w_count != '0);
    assign bus.inst_pc     = w_head_pc;
    assign bus.inst_data   = w_head_data;
    assign bus.busy        = (r_state == ST_RUN);
    assign bus.fetch_count = r_fetch_cnt;

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Bench for imem_fetch_ctrl: directed table, async-reset sequence, and random
// stimulus checked against a queue-based reference model.
module tb_imem_fetch_ctrl;
    import imem_fetch_ctrl_pkg::*;

    localparam int PC_W  = 8;
    localparam int DEPTH = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    imem_fetch_ctrl_if #(.PC_W(PC_W)) bus();

    imem_fetch_ctrl #(.PC_W(PC_W), .DEPTH(DEPTH)) dut (
        .i_clk   (clk),
        .i_reset (rst),
        .bus     (bus)
    );

    // Instruction memory: word i holds 0x1000_0000 + i.
    assign bus.imem_data = 32'h1000_0000 + 32'(bus.imem_addr);

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [7:0]  pc;
        logic [31:0] data;
    } ent_t;

    ent_t       m_q[$];
    bit         m_run;
    logic [7:0] m_pc;
    int         m_fc;

    task automatic model_reset();
        m_q.delete();
        m_run = 1'b0;
        m_pc  = 8'h00;
        m_fc  = 0;
    endtask

    task automatic model_step();
        bit   pop;
        bit   room;
        ent_t e;
        pop = (m_q.size() != 0) && bus.inst_ready;
        if (bus.halt) begin
            m_run = 1'b0;
            m_q.delete();
        end else if (bus.redirect) begin
            m_q.delete();
            m_pc = bus.redirect_pc & 8'hFC;
        end else if (!m_run) begin
            if (bus.start) begin
                m_run = 1'b1;
                m_pc  = bus.start_pc & 8'hFC;
            end
        end else begin
            room = (m_q.size() < DEPTH) || pop;
            if (pop) void'(m_q.pop_front());
            if (room) begin
                e.pc   = m_pc;
                e.data = 32'h1000_0000 + 32'(m_pc / 8'd4);
                m_q.push_back(e);
                m_pc = m_pc + 8'd4;
                if (m_fc < 65535) m_fc++;
            end
        end
    endtask

    function automatic logic [63:0] model_vec();
        logic [7:0]  a;
        logic [7:0]  hp;
        logic [31:0] hd;
        a  = m_pc >> 2;
        hp = 8'h00;
        hd = 32'h0;
        if (m_q.size() != 0) begin
            hp = m_q[0].pc;
            hd = m_q[0].data;
        end
        return {m_q.size() != 0, m_run, hp, hd, 16'(m_fc), a[5:0]};
    endfunction

    function automatic logic [63:0] dut_vec();
        return {bus.inst_valid, bus.busy, bus.inst_pc, bus.inst_data,
                bus.fetch_count, bus.imem_addr};
    endfunction

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s t=%0t: got valid=%0b busy=%0b pc=%h data=%h fc=%0d addr=%h, want valid=%0b busy=%0b pc=%h data=%h fc=%0d addr=%h",
                     name, $time, got[63], got[62], got[61:54], got[53:22], got[21:6], got[5:0],
                     exp[63], exp[62], exp[61:54], exp[53:22], exp[21:6], exp[5:0]);
        end
    endtask

    // Inputs are already driven; advance one edge and compare at the falling edge.
    task automatic step();
        model_step();
        @(posedge clk);
        @(negedge clk);
        check("model", dut_vec(), model_vec());
    endtask

    task automatic drive(input logic st, input logic [7:0] spc, input logic h,
                         input logic rd, input logic [7:0] rpc, input logic rdy);
        bus.start       = st;
        bus.start_pc    = spc;
        bus.halt        = h;
        bus.redirect    = rd;
        bus.redirect_pc = rpc;
        bus.inst_ready  = rdy;
    endtask

    typedef struct {
        logic        start;
        logic [7:0]  spc;
        logic        halt;
        logic        redir;
        logic [7:0]  rpc;
        logic        ready;
        logic        valid;
        logic        busy;
        logic [7:0]  ipc;
        logic [31:0] idata;
        logic [15:0] fc;
        logic [5:0]  addr;
    } vec_t;

    vec_t tbl[18];

    initial begin
        // start, spc, halt, redir, rpc, ready | valid, busy, inst_pc, inst_data, fetch_count, imem_addr
        tbl[0]  = '{1'b1, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'h00, 32'h0,         16'd0,  6'h00};
        tbl[1]  = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h00, 32'h1000_0000, 16'd1,  6'h01};
        tbl[2]  = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h04, 32'h1000_0001, 16'd2,  6'h02};
        tbl[3]  = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h08, 32'h1000_0002, 16'd3,  6'h03};
        tbl[4]  = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 8'h08, 32'h1000_0002, 16'd4,  6'h04};
        tbl[5]  = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 8'h08, 32'h1000_0002, 16'd4,  6'h04};
        tbl[6]  = '{1'b0, 8'h00, 1'b0, 1'b1, 8'h42, 1'b1, 1'b0, 1'b1, 8'h00, 32'h0,         16'd4,  6'h10};
        tbl[7]  = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h40, 32'h1000_0010, 16'd5,  6'h11};
        tbl[8]  = '{1'b0, 8'h00, 1'b1, 1'b1, 8'h80, 1'b1, 1'b0, 1'b0, 8'h00, 32'h0,         16'd5,  6'h11};
        tbl[9]  = '{1'b1, 8'h20, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 32'h0,         16'd5,  6'h11};
        tbl[10] = '{1'b0, 8'h00, 1'b0, 1'b1, 8'hF9, 1'b1, 1'b0, 1'b0, 8'h00, 32'h0,         16'd5,  6'h3E};
        tbl[11] = '{1'b1, 8'hFB, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'h00, 32'h0,         16'd5,  6'h3E};
        tbl[12] = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'hF8, 32'h1000_003E, 16'd6,  6'h3F};
        tbl[13] = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'hFC, 32'h1000_003F, 16'd7,  6'h00};
        tbl[14] = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h00, 32'h1000_0000, 16'd8,  6'h01};
        tbl[15] = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h04, 32'h1000_0001, 16'd9,  6'h02};
        tbl[16] = '{1'b1, 8'h80, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 8'h04, 32'h1000_0001, 16'd10, 6'h03};
        tbl[17] = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 32'h0,         16'd10, 6'h03};

        drive(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("reset", dut_vec(), 64'h0);
        rst = 1'b0;
        model_reset();

        for (int i = 0; i < 18; i++) begin
            drive(tbl[i].start, tbl[i].spc, tbl[i].halt, tbl[i].redir, tbl[i].rpc, tbl[i].ready);
            model_step();
            @(posedge clk);
            @(negedge clk);
            check($sformatf("tbl[%0d]", i), dut_vec(),
                  {tbl[i].valid, tbl[i].busy, tbl[i].ipc, tbl[i].idata, tbl[i].fc, tbl[i].addr});
            check("model", dut_vec(), model_vec());
        end

        // Fill the queue, then hit reset between edges.
        drive(1'b1, 8'h10, 1'b0, 1'b0, 8'h00, 1'b0);
        step();
        drive(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0);
        repeat (3) step();
        @(posedge clk);
        #2 rst = 1'b1;
        #1 check("async_reset", dut_vec(), 64'h0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        drive(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1);
        repeat (4) step();
        check("no_restart", dut_vec(), 64'h0);

        for (int i = 0; i < 3000; i++) begin
            drive($urandom_range(0, 19) == 0, 8'($urandom),
                  $urandom_range(0, 39) == 0,
                  $urandom_range(0, 24) == 0, 8'($urandom),
                  $urandom_range(0, 3) != 0);
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/imem_fetch_ctrl.md
IMEM_FETCH_CTRL -- requirements
Module: imem_fetch_ctrl

Interface
REQ-001 Parameter PC_W, default 8, byte-address program-counter width.
REQ-002 Parameter DEPTH, default 2, fetch-queue entries (power of two, ≥2).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-high; clears all state immediately.
REQ-005 start  input  1  one-cycle pulse; begins fetching at start_pc.
REQ-006 start_pc  input  PC_W  byte address of first instruction.
REQ-007 halt  input  1  level; stop fetching and flush the queue.
REQ-008 redirect  input  1  one-cycle pulse; branch/jump target valid.
REQ-009 redirect_pc  input  PC_W  new fetch byte address.
REQ-010 imem_addr  output  6  word address to instruction memory, equal to pc[7:2].
REQ-011 imem_data  input  32  combinational read data for imem_addr.
REQ-012 inst_valid  output  1  queue head holds a valid instruction.
REQ-013 inst_ready  input  1  consumer accepts the head this cycle.
REQ-014 inst_data  output  32  head instruction word.
REQ-015 inst_pc  output  PC_W  byte address of the head instruction.
REQ-016 busy  output  1  high in RUN state.
REQ-017 fetch_count  output  16  instructions enqueued since reset, saturating at 0xFFFF.

Function
REQ-018 States: IDLE, RUN; reset enters IDLE.
REQ-019 IDLE→RUN on start (halt low): pc←start_pc with bits[1:0] forced to 0; no enqueue in that cycle.
REQ-020 RUN→IDLE on halt: queue flushed, pc held; halt in IDLE has no effect beyond keeping state IDLE.
REQ-021 Priority in one cycle: reset > halt > redirect > start; start is ignored in RUN.
REQ-022 Enqueue in RUN when no halt/redirect and (count<DEPTH or pop this cycle): entry {pc, imem_data} written, pc←pc+4.
REQ-023 Pop occurs when inst_valid & inst_ready; head advances on that edge.
REQ-024 Simultaneous push and pop at full or non-empty queue: both take effect; count unchanged.
REQ-025 Full queue with no pop: no enqueue, pc and imem_addr held stable.
REQ-026 Redirect (in RUN or IDLE): queue flushed, pc←redirect_pc with bits[1:0] cleared, no enqueue that cycle; any concurrent pop is discarded; state unchanged.
REQ-027 pc wraps modulo 2^PC_W (e.g. 0xFC+4→0x00) without error.
REQ-028 inst_valid = (count≠0); inst_data/inst_pc reflect the head entry, 0 when empty.
REQ-029 Fetch latency: instruction at address A, fetched in cycle n, is visible at inst_* in cycle n+1.
REQ-030 fetch_count increments by 1 per enqueue, saturates at 0xFFFF, unaffected by flush.
REQ-031 inst_ready while inst_valid low has no effect.

Reset
REQ-032 On reset assertion, asynchronously: state=IDLE, pc=0, count=0, read/write pointers=0, fetch_count=0.
REQ-033 Reset values: imem_addr=0, inst_valid=0, inst_data=0, inst_pc=0, busy=0, fetch_count=0.
REQ-034 Reset mid-RUN discards all queued entries; the first activity after release requires a new start.

Structure
REQ-035 Shared package holds the state enum (IDLE, RUN), PC_W default, and the instruction word width constant (32).
REQ-036 Queue implemented as sub-module fetch_fifo (DEPTH×(32+PC_W), push/pop/flush, count output); controller FSM, pc, and counter live in imem_fetch_ctrl.

Verification
REQ-037 Memory preloaded with word i = 0x1000_0000+i; start, start_pc=0x00, inst_ready=1 -> inst_pc 0x00,0x04,0x08… one per cycle, inst_data 0x10000000,0x10000001…; first valid 1 cycle after the first fetch.
REQ-038 inst_ready=0 for 5 cycles after start -> exactly DEPTH=2 entries (pc 0x00, 0x04), imem_addr held at 2, fetch_count=2.
REQ-039 Redirect to 0x42 while queue full, with concurrent pop -> next inst_pc=0x40, data=0x10000010; no stale entry emerges.
REQ-040 start_pc=0xF8 -> inst_pc sequence 0xF8,0xFC,0x00,0x04.
REQ-041 Assert reset asynchronously mid-RUN between edges -> inst_valid, busy, and fetch_count all 0 before the next edge; inst_valid stays 0 until start.
REQ-042 Halt and redirect in the same cycle -> IDLE, queue empty, pc=redirect_pc unchanged (redirect ignored), busy=0.
